// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the instruction fetch stage
package fetch_pkg;
    localparam int INSTR_W = 32;

    localparam int OPC_HI = 31;
    localparam int OPC_LO = 26;
    localparam int RD_HI  = 25;
    localparam int RD_LO  = 21;
    localparam int RS_HI  = 20;
    localparam int RS_LO  = 16;
    localparam int RT_HI  = 15;
    localparam int RT_LO  = 11;
    localparam int IMM_HI = 20;
    localparam int IMM_LO = 0;

    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_ONE,
        OCC_TWO
    } occ_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// rtl/fetch_skid_buf.sv - IF/ID output register with one-entry skid for stalled responses
module fetch_skid_buf
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               resp_valid,
    input  logic [31:0]        resp_pc,
    input  logic [INSTR_W-1:0] resp_instr,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [31:0]        id_pc,
    output logic [INSTR_W-1:0] id_instr
);
    logic               skid_valid;
    logic [31:0]        skid_pc;
    logic [INSTR_W-1:0] skid_instr;
    logic               out_free;
    occ_e               occ;

    assign out_free = !id_valid || id_ready;

    always_comb begin
        occ = OCC_EMPTY;
        if (skid_valid)
            occ = OCC_TWO;
        else if (id_valid)
            occ = OCC_ONE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_valid   <= 1'b0;
            id_pc      <= '0;
            id_instr   <= '0;
            skid_valid <= 1'b0;
            skid_pc    <= '0;
            skid_instr <= '0;
        end else if (flush) begin
            id_valid   <= 1'b0;
            skid_valid <= 1'b0;
        end else if (resp_valid) begin
            if (out_free && skid_valid) begin
                // Older skid word goes first to keep program order.
                id_valid   <= 1'b1;
                id_pc      <= skid_pc;
                id_instr   <= skid_instr;
                skid_pc    <= resp_pc;
                skid_instr <= resp_instr;
            end else if (out_free) begin
                id_valid <= 1'b1;
                id_pc    <= resp_pc;
                id_instr <= resp_instr;
            end else begin
                skid_valid <= 1'b1;
                skid_pc    <= resp_pc;
                skid_instr <= resp_instr;
            end
        end else if (out_free) begin
            if (skid_valid) begin
                id_valid   <= 1'b1;
                id_pc      <= skid_pc;
                id_instr   <= skid_instr;
                skid_valid <= 1'b0;
            end else begin
                id_valid <= 1'b0;
            end
        end
    end

    skid_no_overflow: assert property (@(posedge clk) disable iff (!rst_n || flush)
        !(resp_valid && !out_free && occ == OCC_TWO));
endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - fetch stage: PC, memory request, redirect and IF/ID field split
module instr_fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               id_ready,
    output logic               id_valid,
    output logic [31:0]        id_pc,
    output logic [INSTR_W-1:0] id_instr,
    output logic [5:0]         id_opcode,
    output logic [4:0]         id_rd,
    output logic [4:0]         id_rs,
    output logic [4:0]         id_rt,
    output logic [20:0]        id_imm,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc
);
    logic [31:0] pc;
    logic [31:0] resp_pc;
    logic        resp_pending;
    logic        stall;
    logic        unused_low_bits;

    assign stall           = id_valid && !id_ready;
    assign imem_req        = rst_n && !redirect_valid && !stall;
    assign imem_addr       = pc;
    assign unused_low_bits = ^redirect_pc[1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            resp_pending <= 1'b0;
            resp_pc      <= '0;
        end else if (redirect_valid) begin
            pc           <= {redirect_pc[31:2], 2'b00};
            resp_pending <= 1'b0;
        end else if (imem_req) begin
            pc           <= pc + PC_STEP;
            resp_pending <= 1'b1;
            resp_pc      <= pc;
        end else begin
            resp_pending <= 1'b0;
        end
    end

    // A redirect also drops the word returning this cycle via flush.
    fetch_skid_buf u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .resp_valid (resp_pending),
        .resp_pc    (resp_pc),
        .resp_instr (imem_rdata),
        .id_ready   (id_ready),
        .id_valid   (id_valid),
        .id_pc      (id_pc),
        .id_instr   (id_instr)
    );

    assign id_opcode = id_instr[OPC_HI:OPC_LO];
    assign id_rd     = id_instr[RD_HI:RD_LO];
    assign id_rs     = id_instr[RS_HI:RS_LO];
    assign id_rt     = id_instr[RT_HI:RT_LO];
    assign id_imm    = id_instr[IMM_HI:IMM_LO];
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch with randomized scoreboard
module tb_instr_fetch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_ready = 1'b1;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [5:0]  id_opcode;
    logic [4:0]  id_rd, id_rs, id_rt;
    logic [20:0] id_imm;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] last_addr = 32'h0;

    int passed = 0;
    int total = 0;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .id_ready(id_ready), .id_valid(id_valid),
        .id_pc(id_pc), .id_instr(id_instr), .id_opcode(id_opcode), .id_rd(id_rd),
        .id_rs(id_rs), .id_rt(id_rt), .id_imm(id_imm),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a == 32'h0000_0200) ? 32'h0C3F_FFFF : a;
    endfunction

    // Synchronous memory: word for the address presented at the previous edge.
    always @(posedge clk) last_addr <= imem_addr;
    assign imem_rdata = word_of(last_addr);

    task automatic step(input logic rst, input logic rdy, input logic rv, input logic [31:0] rpc);
        @(negedge clk);
        rst_n = rst; id_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        #1;
    endtask

    task automatic test_reset();
        step(1'b0, 1'b1, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0);
        total++; if (imem_req !== 1'b0) $display("FAIL rst_req: got %b exp 0", imem_req); else passed++;
        total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr: got %h exp 0", imem_addr); else passed++;
        total++; if (id_valid !== 1'b0) $display("FAIL rst_valid: got %b exp 0", id_valid); else passed++;
        total++; if (id_pc !== 32'h0 || id_instr !== 32'h0) $display("FAIL rst_out: got pc %h instr %h exp 0", id_pc, id_instr); else passed++;
        total++; if ({id_opcode, id_rd, id_rs, id_rt, id_imm} !== 42'h0) $display("FAIL rst_fields: got %h exp 0", {id_opcode, id_rd, id_rs, id_rt, id_imm}); else passed++;
    endtask

    task automatic test_startup();
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL start_c1: got req %b addr %h exp 1 0", imem_req, imem_addr); else passed++;
        total++; if (id_valid !== 1'b0) $display("FAIL start_c1_valid: got %b exp 0", id_valid); else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (imem_addr !== 32'h4 || id_valid !== 1'b0) $display("FAIL start_c2: got addr %h valid %b exp 4 0", imem_addr, id_valid); else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h0) $display("FAIL start_c3: got valid %b pc %h exp 1 0", id_valid, id_pc); else passed++;
        for (int k = 4; k <= 10; k++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            total++;
            if (id_valid !== 1'b1 || id_pc !== 32'(4 * (k - 3)) || id_instr !== word_of(32'(4 * (k - 3))) || imem_addr !== 32'(4 * (k - 1)))
                $display("FAIL stream_%0d: got valid %b pc %h instr %h addr %h exp pc %h", k, id_valid, id_pc, id_instr, imem_addr, 32'(4 * (k - 3)));
            else passed++;
        end
    endtask

    task automatic test_stall();
        int rises = 0;
        logic prev_skid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step(1'b1, 1'b0, 1'b0, 32'h0);
            if (dut.u_skid.skid_valid && !prev_skid) rises++;
            prev_skid = dut.u_skid.skid_valid;
            total++;
            if (imem_req !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h20)
                $display("FAIL stall_hold_%0d: got req %b valid %b pc %h exp 0 1 00000020", c, imem_req, id_valid, id_pc);
            else passed++;
        end
        for (int j = 0; j < 6; j++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            if (dut.u_skid.skid_valid && !prev_skid) rises++;
            prev_skid = dut.u_skid.skid_valid;
            if (j == 0) begin
                total++; if (imem_req !== 1'b1 || imem_addr !== 32'h28) $display("FAIL stall_release_req: got req %b addr %h exp 1 00000028", imem_req, imem_addr); else passed++;
            end
            total++;
            if (id_valid !== 1'b1 || id_pc !== 32'(32 + 4 * j))
                $display("FAIL stall_resume_%0d: got valid %b pc %h exp 1 %h", j, id_valid, id_pc, 32'(32 + 4 * j));
            else passed++;
        end
        total++; if (rises !== 1) $display("FAIL skid_fill_count: got %0d exp 1", rises); else passed++;
    endtask

    task automatic test_redirect_two();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b1, 32'h0000_0103);
        total++; if (dut.u_skid.skid_valid !== 1'b1 || id_valid !== 1'b1) $display("FAIL redir_two_state: got skid %b valid %b exp 1 1", dut.u_skid.skid_valid, id_valid); else passed++;
        total++; if (imem_req !== 1'b0) $display("FAIL redir_req: got %b exp 0", imem_req); else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL redir_n1: got valid %b req %b addr %h exp 0 1 00000100", id_valid, imem_req, imem_addr); else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (id_valid !== 1'b0) $display("FAIL redir_n2: got valid %b exp 0", id_valid); else passed++;
        for (int j = 0; j < 4; j++) begin
            step(1'b1, 1'b1, 1'b0, 32'h0);
            total++;
            if (id_valid !== 1'b1 || id_pc !== 32'(32'h100 + 4 * j) || id_instr !== word_of(32'(32'h100 + 4 * j)))
                $display("FAIL redir_seq_%0d: got valid %b pc %h instr %h exp pc %h", j, id_valid, id_pc, id_instr, 32'(32'h100 + 4 * j));
            else passed++;
        end
    endtask

    task automatic test_decode();
        step(1'b1, 1'b1, 1'b1, 32'h0000_0203);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h200 || id_instr !== 32'h0C3F_FFFF) $display("FAIL dec_word: got valid %b pc %h instr %h exp 1 00000200 0c3fffff", id_valid, id_pc, id_instr); else passed++;
        total++;
        if (id_opcode !== 6'h03 || id_rd !== 5'h01 || id_rs !== 5'h1F || id_rt !== 5'h1F || id_imm !== 21'h1F_FFFF)
            $display("FAIL dec_fields: got %h %h %h %h %h exp 03 01 1f 1f 1fffff", id_opcode, id_rd, id_rs, id_rt, id_imm);
        else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++;
        if (id_pc !== 32'h204 || id_opcode !== 6'h0 || id_rd !== 5'h0 || id_rs !== 5'h0 || id_rt !== 5'h0 || id_imm !== 21'h204)
            $display("FAIL dec_next: got pc %h fields %h %h %h %h %h exp 00000204 0 0 0 0 204", id_pc, id_opcode, id_rd, id_rs, id_rt, id_imm);
        else passed++;
    endtask

    task automatic test_wrap();
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFC);
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got req %b addr %h exp 1 fffffffc", imem_req, imem_addr); else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr1: got %h exp 00000000", imem_addr); else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (id_valid !== 1'b1 || id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_out0: got valid %b pc %h exp 1 fffffffc", id_valid, id_pc); else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h0) $display("FAIL wrap_out1: got valid %b pc %h exp 1 0", id_valid, id_pc); else passed++;
    endtask

    task automatic test_reset_stall();
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        total++; if (dut.u_skid.skid_valid !== 1'b1) $display("FAIL rs_skid_full: got %b exp 1", dut.u_skid.skid_valid); else passed++;
        step(1'b0, 1'b0, 1'b0, 32'h0);
        total++; if (imem_req !== 1'b0) $display("FAIL rs_req_in_reset: got %b exp 0", imem_req); else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++;
        if (id_valid !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b1 || dut.u_skid.skid_valid !== 1'b0)
            $display("FAIL rs_after: got valid %b addr %h req %b skid %b exp 0 0 1 0", id_valid, imem_addr, imem_req, dut.u_skid.skid_valid);
        else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (id_valid !== 1'b0 || imem_addr !== 32'h4) $display("FAIL rs_c2: got valid %b addr %h exp 0 4", id_valid, imem_addr); else passed++;
        step(1'b1, 1'b1, 1'b0, 32'h0);
        total++; if (id_valid !== 1'b1 || id_pc !== 32'h0 || id_instr !== 32'h0) $display("FAIL rs_c3: got valid %b pc %h instr %h exp 1 0 0", id_valid, id_pc, id_instr); else passed++;
    endtask

    // Scoreboard: decode must see the consecutive word stream starting at each redirect target.
    task automatic test_random();
        logic [31:0] exp_pc;
        logic [31:0] w;
        int since;
        logic rdy, rv, exp_valid, exp_req;
        logic [31:0] rpc;
        int errs = 0;
        rpc = $urandom;
        step(1'b1, 1'b1, 1'b1, rpc);
        exp_pc = {rpc[31:2], 2'b00};
        since = 1;
        for (int i = 0; i < 400; i++) begin
            rdy = ($urandom_range(0, 9) < 7);
            rv  = ($urandom_range(0, 24) == 0);
            rpc = $urandom;
            step(1'b1, rdy, rv, rpc);
            exp_valid = (since >= 3);
            exp_req = !rv && !(exp_valid && !rdy);
            w = word_of(exp_pc);
            total++;
            if (imem_req !== exp_req || id_valid !== exp_valid) begin
                if (errs < 10) $display("FAIL rnd_ctl_%0d: got req %b valid %b exp %b %b", i, imem_req, id_valid, exp_req, exp_valid);
                errs++;
            end else passed++;
            total++;
            if (imem_addr !== ((since == 1) ? exp_pc : (since == 2) ? exp_pc + 32'd4 : exp_pc + 32'd8)) begin
                if (errs < 10) $display("FAIL rnd_addr_%0d: got %h since %0d exp_pc %h", i, imem_addr, since, exp_pc);
                errs++;
            end else passed++;
            if (exp_valid) begin
                total++;
                if (id_pc !== exp_pc || id_instr !== w || id_opcode !== 6'(w >> 26) || id_rd !== 5'(w >> 21) ||
                    id_rs !== 5'(w >> 16) || id_rt !== 5'(w >> 11) || id_imm !== 21'(w))
                begin
                    if (errs < 10) $display("FAIL rnd_data_%0d: got pc %h instr %h exp %h %h", i, id_pc, id_instr, exp_pc, w);
                    errs++;
                end else passed++;
            end
            if (rv) begin
                exp_pc = {rpc[31:2], 2'b00};
                since = 1;
            end else begin
                if (exp_valid && rdy) exp_pc = exp_pc + 32'd4;
                if (since < 10) since++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_stall();
        test_redirect_two();
        test_decode();
        test_wrap();
        test_reset_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-issue core. Holds the program counter, issues word requests to a synchronous instruction memory (one-cycle read latency), and registers each returned word into the IF/ID output register. It also splits the word into fields; `id_imm` feeds the downstream `sign_extend` stage directly. A one-entry skid buffer absorbs the in-flight word when decode stalls, and a redirect port from execute reloads the PC and flushes the stage.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value after reset; word aligned.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `imem_req`  out  1  read request this cycle.
- `imem_addr`  out  32  byte address of the request; always the PC register, bits [1:0] = 0.
- `imem_rdata`  in  32  instruction word, valid in the cycle after a request.
- `id_ready`  in  1  decode accepts `id_*` this cycle.
- `id_valid`  out  1  `id_*` outputs hold a valid instruction.
- `id_pc`  out  32  address of the instruction in `id_instr`.
- `id_instr`  out  32  raw instruction word.
- `id_opcode`  out  6  `id_instr[31:26]`.
- `id_rd`  out  5  `id_instr[25:21]`.
- `id_rs`  out  5  `id_instr[20:16]`.
- `id_rt`  out  5  `id_instr[15:11]`.
- `id_imm`  out  21  `id_instr[20:0]`, unextended.
- `redirect_valid`  in  1  execute requests a PC change.
- `redirect_pc`  in  32  new PC; bits [1:0] are ignored and forced to 0.

## Operation
- Registers:
  - `pc`
  - `resp_pending` plus `resp_pc`, covering the request in flight
  - skid entry with `skid_valid`, `skid_pc` and `skid_instr`
  - output register with `id_valid`, `id_pc` and `id_instr`
- Field outputs are pure slices of `id_instr`.
- Stall condition: `id_valid && !id_ready`.
- Request rule: `imem_req = rst_n && !redirect_valid && !(id_valid && !id_ready)`.
- On each edge where `imem_req = 1`:
  - `pc <= pc + 4`, wrapping modulo 2^32.
  - `resp_pending <= 1`, `resp_pc <= pc`.
- Otherwise, `resp_pending <= 0`.
- Response placement, in priority order:
  - Output register free (`!id_valid || id_ready`) and skid full: the skid entry moves to the output register, and the response moves into the skid.
  - Output register free and skid empty: the response goes to the output register.
  - Output register stalled: the response goes to the skid.
- The request rule guarantees the skid never overflows. An overflow attempt is a design error and is flagged by an assertion.
- With no response and a free output register, the skid entry, if any, moves to the output register. If both are empty, `id_valid <= 0`.
- Occupancy states (per-cycle count of valid words held in stage): EMPTY (0), ONE (output only), TWO (output + skid). TWO is reached only from ONE under stall with a response arriving, and is left only via `id_ready = 1` or a redirect.
- Redirect, which has priority over all of the above:
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - `id_valid`, `skid_valid` and `resp_pending` are cleared; the in-flight response is discarded.
  - `imem_req = 0` in the redirect cycle.
- Reset (`rst_n = 0` at an edge):
  - `pc <= RESET_PC`.
  - `id_valid`, `skid_valid` and `resp_pending` are cleared.
  - `id_pc`, `id_instr`, `skid_*` and `resp_pc` are set to 0.
- Reset mid-stall or mid-redirect behaves identically: all state is discarded.

## Timing
- Output reset values:
  - `imem_req = 0` while `rst_n = 0`.
  - `imem_addr = RESET_PC` once reset has been applied.
  - `id_valid = 0`; `id_pc`, `id_instr` and all fields are 0.
- Fetch latency: a request in cycle t returns data in t+1, and `id_valid = 1` in t+2.
- First cycle with `rst_n = 1`: request to `RESET_PC`, so `id_valid` rises two cycles later.
- Throughput: one instruction per cycle while `id_ready = 1`.
- Stall:
  - If `id_ready` drops in cycle t with `id_valid = 1`, there is no request in t, and the word requested in t-1 lands in the skid.
  - When `id_ready` returns in cycle u, the skid entry is presented in u+1 and a request issues in u, so there is no bubble.
- Redirect in cycle N:
  - `id_valid = 0` in N+1 and N+2.
  - `imem_addr = redirect_pc` with a request in N+1.
  - The target instruction appears in N+3.
- A redirect coincident with a stall or a skid-full state takes effect the same way; the skid contents are lost.

## Structure
- Package `fetch_pkg` holds:
  - `INSTR_W = 32`
  - field position constants `OPC_HI/LO`, `RD_HI/LO`, `RS_HI/LO`, `RT_HI/LO`, `IMM_HI/LO`
  - `PC_STEP = 4`
  - default `RESET_PC`
- Sub-module `fetch_skid_buf`: one-entry buffer with the output register and the placement/occupancy logic. `instr_fetch` keeps the PC, the request rule and the redirect handling.

## Test plan
- Reset, then release with `id_ready = 1` and memory returning word = address: addresses 0, 4, 8… issue on consecutive cycles; `id_valid` rises on the 3rd cycle after release with `id_pc = 0`; one instruction per cycle follows.
- Decode a word of 32'h0C3F_FFFF: `id_opcode = 6'h03`, `id_rd = 5'h01`, `id_rs = 5'h1F`, `id_rt = 5'h1F`, `id_imm = 21'h1F_FFFF`.
- Hold `id_ready = 0` for 5 cycles mid-stream:
  - `imem_req` drops the same cycle.
  - The skid fills exactly once.
  - On release, the `id_pc` sequence continues with no gap or duplicate.
- Assert `redirect_valid` with `redirect_pc = 32'h0000_0103` while in state TWO:
  - `id_valid = 0` for 2 cycles.
  - The next `id_pc = 32'h0000_0100`.
  - No pre-redirect word ever appears on the outputs.
- With `pc = 32'hFFFF_FFFC`, one more request: the PC wraps, and the next `imem_addr = 32'h0000_0000`.
- Assert `rst_n = 0` for one cycle during a stall with the skid full: the next cycle shows `id_valid = 0`, `imem_addr = RESET_PC`, and a normal restart.
